jk_updown_counter: RTL and testbench

- Parametrised successor to the fixed 4-bit JK-flip-flop ripple-enable up counter.
- Generalised to WIDTH bits, with arbitrary MODULUS, up/down direction, count enable, synchronous parallel load, terminal-count output and wrap pulse.
- The state register is built from one JK flip-flop cell per bit.
- Used as a general-purpose event/divider counter, e.g. a BCD digit with MODULUS=10 and cascaded via tc.

---
 rtl/jk_counter_pkg.sv | 28 ++
 rtl/jk_ff_sync.sv | 32 +++
 rtl/jk_updown_counter.sv | 121 ++++++++++++
 tb/tb_jk_updown_counter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK up/down counter: direction codes, JK cell encodings, load clamp.
// Saturating mode is selected by defining JK_COUNTER_SAT_EN; see jk_updown_counter.
package jk_counter_pkg;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Wide enough to hold any legal MODULUS (up to 2**16).
  localparam int MAX_WIDTH = 16;
  typedef logic [MAX_WIDTH:0] cnt_wide_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_t;

  function automatic cnt_wide_t clamp_load(input cnt_wide_t val, input cnt_wide_t modulus);
    return (val < modulus) ? val : (modulus - cnt_wide_t'(1));
  endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Single-bit JK flip-flop with synchronous active-high reset to RESET_BIT.
module jk_ff_sync
  import jk_counter_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= RESET_BIT;
    end else begin
      case ({j, k})
        JK_HOLD: q_reg <= q_reg;
        JK_RST:  q_reg <= 1'b0;
        JK_SET:  q_reg <= 1'b1;
        JK_TGL:  q_reg <= ~q_reg;
        default: q_reg <= q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter with load, terminal count and wrap pulse, built from JK cells.
// Define JK_COUNTER_SAT_EN for saturating mode (holds at the ends, wrapped tied low).
module jk_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  step_t            step;

  assign load_clamped = WIDTH'(clamp_load(cnt_wide_t'(load_val), cnt_wide_t'(MODULUS)));

  // Reset is applied inside each JK cell, so it is not part of this decode.
  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (en) begin
      step = (up_dn == UP) ? STEP_UP : STEP_DOWN;
    end
  end

`ifdef JK_COUNTER_SAT_EN

  always_comb begin
    q_next = q_reg;
    case (step)
      STEP_LOAD: q_next = load_clamped;
      STEP_UP:   q_next = (q_reg < MAX_Q) ? q_reg + WIDTH'(1) : MAX_Q;
      STEP_DOWN: q_next = (q_reg != '0) ? q_reg - WIDTH'(1) : '0;
      default:   q_next = q_reg;
    endcase
  end

  assign wrapped = 1'b0;

`else

  logic wrap_next;
  logic wrapped_reg;

  // An out-of-range q fails the "< MAX_Q" test, so an up step from it wraps to 0.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    case (step)
      STEP_LOAD: q_next = load_clamped;
      STEP_UP: begin
        if (q_reg < MAX_Q) begin
          q_next = q_reg + WIDTH'(1);
        end else begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end
      STEP_DOWN: begin
        if (q_reg != '0) begin
          q_next = q_reg - WIDTH'(1);
        end else begin
          q_next    = MAX_Q;
          wrap_next = 1'b1;
        end
      end
      default: q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrapped_reg <= 1'b0;
    end else begin
      wrapped_reg <= wrap_next;
    end
  end

  assign wrapped = wrapped_reg;

`endif

  // Drive each cell only toward the bit it must change to; toggle is never requested.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign j_vec[gi] = q_next[gi] & ~q_reg[gi];
      assign k_vec[gi] = ~q_next[gi] & q_reg[gi];

      jk_ff_sync #(
        .RESET_BIT(RESET_Q[gi])
      ) u_cell (
        .clk  (clk),
        .reset(reset),
        .j    (j_vec[gi]),
        .k    (k_vec[gi]),
        .q    (q_reg[gi])
      );
    end
  endgenerate

  assign q  = q_reg;
  assign tc = en & (((up_dn == UP) & (q_reg == MAX_Q)) | ((up_dn == DN) & (q_reg == '0)));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter: a MODULUS=16 and a MODULUS=10 instance on shared stimulus.
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q16;
  logic [3:0] q10;
  logic       tc16;
  logic       tc10;
  logic       w16;
  logic       w10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_m16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q16), .tc(tc16), .wrapped(w16)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_m10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q10), .tc(tc10), .wrapped(w10)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int up_exp;
    int dn_exp[5];
    dn_exp = '{2, 1, 0, 9, 8};

    reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    check_val("rst_q16", int'(q16), 0);
    check_val("rst_w16", int'(w16), 0);
    check_val("rst_q10", int'(q10), 0);
    check_val("rst_w10", int'(w10), 0);

`ifndef JK_COUNTER_SAT_EN
    // Up count, both moduli in parallel.
    reset = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_val($sformatf("up16_q_%0d", i), int'(q16), i % 16);
      check_val($sformatf("up16_w_%0d", i), int'(w16), (i == 16) ? 1 : 0);
      check_val($sformatf("up16_tc_%0d", i), int'(tc16), (i == 15) ? 1 : 0);
      up_exp = i % 10;
      check_val($sformatf("up10_q_%0d", i), int'(q10), up_exp);
      check_val($sformatf("up10_w_%0d", i), int'(w10), (up_exp == 0) ? 1 : 0);
      check_val($sformatf("up10_tc_%0d", i), int'(tc10), (up_exp == 9) ? 1 : 0);
    end

    // Hold at 6.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("hold_q_%0d", i), int'(q10), 6);
      check_val($sformatf("hold_tc_%0d", i), int'(tc10), 0);
      check_val($sformatf("hold_w_%0d", i), int'(w10), 0);
    end

    // Load 3 then count down through the wrap.
    load = 1'b1; load_val = 4'd3; en = 1'b1; up_dn = 1'b0;
    tick();
    check_val("ld3_q", int'(q10), 3);
    check_val("ld3_w", int'(w10), 0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("dn_q_%0d", i), int'(q10), dn_exp[i]);
      check_val($sformatf("dn_w_%0d", i), int'(w10), (dn_exp[i] == 9) ? 1 : 0);
      check_val($sformatf("dn_tc_%0d", i), int'(tc10), (dn_exp[i] == 0) ? 1 : 0);
    end

    // Load clamp with en high; the wide instance takes 13 as-is.
    load = 1'b1; load_val = 4'd13; en = 1'b1; up_dn = 1'b1;
    tick();
    check_val("clamp_q10", int'(q10), 9);
    check_val("clamp_w10", int'(w10), 0);
    check_val("clamp_q16", int'(q16), 13);

    // Reset beats load.
    reset = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    check_val("rst_ld_q10", int'(q10), 0);
    check_val("rst_ld_q16", int'(q16), 0);

    // Direction flip at 0.
    reset = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1;
    tick();
    check_val("flip_hold_q", int'(q10), 0);
    en = 1'b1;
    #1;
    check_val("flip_tc_up", int'(tc10), 0);
    up_dn = 1'b0;
    #1;
    check_val("flip_tc_dn", int'(tc10), 1);
    tick();
    check_val("flip_q", int'(q10), 9);
    check_val("flip_w", int'(w10), 1);

    // Reset clears a pending wrap pulse.
    reset = 1'b1;
    tick();
    check_val("rst_w_clr", int'(w10), 0);
    check_val("rst_q_clr", int'(q10), 0);
`else
    // Saturating up from 8.
    reset = 1'b0; load = 1'b1; load_val = 4'd8; en = 1'b1; up_dn = 1'b1;
    tick();
    check_val("sat_ld8", int'(q10), 8);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("sat_up_q_%0d", i), int'(q10), 9);
      check_val($sformatf("sat_up_tc_%0d", i), int'(tc10), 1);
      check_val($sformatf("sat_up_w_%0d", i), int'(w10), 0);
    end

    // Saturating down from 1.
    load = 1'b1; load_val = 4'd1; up_dn = 1'b0;
    tick();
    check_val("sat_ld1", int'(q10), 1);
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val($sformatf("sat_dn_q_%0d", i), int'(q10), 0);
      check_val($sformatf("sat_dn_tc_%0d", i), int'(tc10), 1);
      check_val($sformatf("sat_dn_w_%0d", i), int'(w10), 0);
    end
    check_val("sat_dn_q16", int'(q16), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
